hawk_att_lkup: RTL and testbench
================================

Name: hawk_att_lkup

Overview:
- ATT lookup engine. Consumes att_lkup_reqpkt_t from the control unit (hppa = 4KB page index).
- Fetches the 64B ATT block that holds the page's entry over the AXI read channel into the hawk_axird_master side.
- Extracts the 8B AttEntry and returns it, with sts and way decoded, to the control unit / page read manager.
- Sits between the control unit and the AXI read master, upstream of the table-update path.

Parameters:
- ATT_BASE, HAWK_ATT_START (64'hFFF6100000): byte base address of the ATT.
- ENTRY_CNT, ATT_ENTRY_CNT (16): number of valid ATT entries. hppa >= ENTRY_CNT is out of range.
- AXI_DW, 512: AXI read data width in bits. Equals BLK_SIZE*BYTE.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- lkup_req_i  in  49  att_lkup_reqpkt_t {hppa[47:0], lookup}
- lkup_ready_o  out  1  request accepted when lookup && lkup_ready_o
- araddr_o  out  64  AXI read address, 64B aligned
- arvalid_o  out  1  AXI AR valid
- arready_i  in  1  AXI AR ready
- rdata_i  in  512  AXI read data
- rresp_i  in  2  AXI read response
- rvalid_i  in  1  AXI R valid
- rlast_i  in  1  AXI R last
- rready_o  out  1  AXI R ready
- resp_valid_o  out  1  lookup result valid
- resp_ready_i  in  1  consumer ready
- resp_entry_o  out  64  AttEntry {zpd_cnt, way, sts}
- resp_hppa_o  out  48  hppa of the result
- resp_err_o  out  1  out-of-range request or AXI error
- inv_i  in  1  invalidate pulse from the table-update path (used only with the cache option)

Behaviour:
- Reset: state IDLE, lkup_ready_o=1, arvalid_o=0, rready_o=0, resp_valid_o=0. araddr_o, resp_entry_o, resp_hppa_o and resp_err_o are all 0. Holding registers are cleared.
- Address arithmetic, done in 64 bits with hppa zero-extended:
  - ent_addr = ATT_BASE + hppa*ATT_ENTRY_SIZE
  - blk_addr = ent_addr with bits [5:0] cleared
  - slot = hppa[2:0]
  - Extracted entry = beat0[slot*64 +: 64]
- FSM states: IDLE, AR, R, RESP.
- IDLE:
  - lkup_ready_o=1. On accept, latch hppa.
  - If hppa >= ENTRY_CNT: go to RESP with resp_err_o=1 and entry=0. No AXI traffic.
  - Otherwise: araddr_o=blk_addr, go to AR.
- AR:
  - arvalid_o=1, lkup_ready_o=0. araddr_o is held stable until arready_i.
  - arvalid_o is never dropped before the handshake.
  - On arvalid_o && arready_i, go to R.
- R:
  - rready_o=1. The first beat (rvalid_i && rready_o) is captured.
  - Further beats are drained and discarded until rlast_i.
  - Any beat with rresp_i != 0 sets a sticky error.
  - On the beat with rlast_i, go to RESP.
  - A single-beat burst takes R for 1 cycle.
- RESP:
  - resp_valid_o=1. resp_entry_o, resp_hppa_o and resp_err_o are registered and stable until resp_valid_o && resp_ready_i.
  - After the handshake, return to IDLE.
- Latency, out-of-range: accept at cycle N, resp_valid_o at N+1.
- Latency, in-range: accept at cycle N, arvalid_o at N+1, resp_valid_o 1 cycle after the rlast beat.
- One lookup in flight. lkup_ready_o=0 in every state except IDLE; no back-to-back accept in the RESP handshake cycle.
- rvalid_i while not in R: ignored (rready_o=0).
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. The AXI master owns cleanup of any outstanding burst.

Optional Feature:
- Macro: HAWK_ATT_LKUP_CACHE_EN.
- Enabled:
  - A one-block cache holds the tag (blk_addr) and the 512-bit data of the last successful fetch.
  - On accept in IDLE with tag match and cache valid, go straight to RESP next cycle with no AR.
  - Fills only on error-free fetches.
  - inv_i=1 clears cache valid in the same cycle. inv_i wins over a fill in the same cycle.
- Disabled: every in-range lookup issues an AXI read. inv_i is ignored.

Decomposition:
- hacd_pkg additions:
  - att_lkup_resppkt_t {AttEntry entry; logic [47:0] hppa; logic err; logic valid}
  - AXI_RESP_OKAY constant
  - Widen axi_rd_resppkt_t.rdata to 512 bits and add rresp[1:0]
- Reuse from hacd_pkg: AttEntry, ATT_ENTRY_SIZE, ATT_ENTRY_PER_BLK.
- Sub-module hawk_att_blk_extract: combinational 512->64 slot mux plus sts/way decode. The FSM stays in the top level.

Test Plan:
- hppa=5, arready_i tied 1, single beat with beat0[383:320]=64'h0100000000012346 -> araddr_o=0xFFF6100000; resp_entry_o sts=2'b10, zpd_cnt=8'h01; resp_err_o=0.
- hppa=9, arready_i low for 3 cycles -> arvalid_o and araddr_o=0xFFF6100040 stable for 4 cycles; entry taken from beat0[127:64].
- hppa=16 -> no arvalid_o; resp_valid_o one cycle after accept; resp_err_o=1; resp_entry_o=0.
- 2-beat burst, rresp_i=2'b10 on beat 2 -> resp_err_o=1; resp_valid_o only after rlast_i.
- resp_ready_i held 0 for 5 cycles -> resp_valid_o and resp_entry_o stable, lkup_ready_o=0 throughout.
- Cache enabled: hppa=1 then hppa=6 -> second lookup has no AR and resp_valid_o at accept+1. Pulse inv_i, repeat hppa=6 -> AR issued. Reset asserted in R -> all outputs return to 0 and lkup_ready_o=1.

Source files
------------

// File: rtl/hawk_att_lkup_pkg.sv
// Shared types and constants for the ATT lookup engine.
//   AttEntry           : 8-byte ATT entry {zpd_cnt, way, sts}
//   att_lkup_reqpkt_t  : lookup request {hppa, lookup}
//   att_lkup_resppkt_t : lookup result {entry, hppa, err, valid}
//   axi_rd_resppkt_t   : one AXI read beat {rdata, rresp, rlast}
//   att_blk_addr()     : 64B-aligned address of the ATT block holding an hppa
package hawk_att_lkup_pkg;

  localparam int BYTE              = 8;
  localparam int BLK_SIZE          = 64;
  localparam int AXI_DW            = BLK_SIZE * BYTE;
  localparam int ATT_ENTRY_SIZE    = 8;
  localparam int ENTRY_W           = ATT_ENTRY_SIZE * BYTE;
  localparam int ATT_ENTRY_PER_BLK = BLK_SIZE / ATT_ENTRY_SIZE;
  localparam int SLOT_W            = $clog2(ATT_ENTRY_PER_BLK);

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [7:0]  zpd_cnt;
    logic [53:0] way;
    logic [1:0]  sts;
  } AttEntry;

  typedef struct packed {
    logic [47:0] hppa;
    logic        lookup;
  } att_lkup_reqpkt_t;

  typedef struct packed {
    AttEntry     entry;
    logic [47:0] hppa;
    logic        err;
    logic        valid;
  } att_lkup_resppkt_t;

  typedef struct packed {
    logic [AXI_DW-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
  } axi_rd_resppkt_t;

  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_RESP} att_state_e;

  function automatic logic [63:0] att_blk_addr(input logic [63:0] base,
                                               input logic [47:0] hppa);
    logic [63:0] ent;
    ent = base + ({16'b0, hppa} * 64'(ATT_ENTRY_SIZE));
    return {ent[63:6], 6'b0};
  endfunction

endpackage

// File: rtl/hawk_att_lkup_if.sv
// AXI read address/data channel bundle between the ATT lookup engine
// (master) and the AXI read master / memory side (slave).
//   araddr/arvalid/arready : read address channel
//   rdata/rresp/rvalid/rlast/rready : read data channel
interface hawk_att_lkup_if;
  import hawk_att_lkup_pkg::*;

  logic [63:0]       araddr;
  logic              arvalid;
  logic              arready;
  logic [AXI_DW-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rlast;
  logic              rready;

  modport master (output araddr, arvalid, rready,
                  input  arready, rdata, rresp, rvalid, rlast);
  modport slave  (input  araddr, arvalid, rready,
                  output arready, rdata, rresp, rvalid, rlast);
endinterface

// File: rtl/hawk_att_blk_extract.sv
// Combinational slot mux: picks one 8-byte ATT entry out of a 64-byte block
// and splits it into its zpd_cnt / way / sts fields.
//   blk_i   : 512-bit ATT block (beat 0 of the fetch or cached copy)
//   slot_i  : entry index within the block (hppa[2:0])
//   entry_o : decoded AttEntry
module hawk_att_blk_extract
  import hawk_att_lkup_pkg::*;
(
  input  logic [AXI_DW-1:0] blk_i,
  input  logic [SLOT_W-1:0] slot_i,
  output AttEntry           entry_o
);
  logic [ENTRY_W-1:0] raw;

  always_comb begin
    raw = '0;
    for (int s = 0; s < ATT_ENTRY_PER_BLK; s++) begin
      if (slot_i == s[SLOT_W-1:0]) raw = blk_i[s*ENTRY_W +: ENTRY_W];
    end
    entry_o.zpd_cnt = raw[63:56];
    entry_o.way     = raw[55:2];
    entry_o.sts     = raw[1:0];
  end
endmodule

// File: rtl/hawk_att_lkup.sv
// ATT lookup engine: accepts one hppa lookup at a time, fetches the 64B ATT
// block holding its entry over AXI read, extracts the 8B entry and returns it.
// Optional macro HAWK_ATT_LKUP_CACHE_EN adds a one-block cache of the last
// error-free fetch (inv_i clears it); without it inv_i is ignored.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   lkup_req_i/lkup_ready_o : request {hppa, lookup}, accepted in IDLE
//   axi                   : AXI read AR/R channels (master modport)
//   resp_valid_o/resp_ready_i : result handshake
//   resp_entry_o, resp_hppa_o, resp_err_o : registered result
//   inv_i                 : cache invalidate pulse
module hawk_att_lkup
  import hawk_att_lkup_pkg::*;
#(
  parameter logic [63:0] ATT_BASE  = 64'hFFF6100000,
  parameter int unsigned ENTRY_CNT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  att_lkup_reqpkt_t lkup_req_i,
  output logic             lkup_ready_o,
  hawk_att_lkup_if.master  axi,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [63:0]      resp_entry_o,
  output logic [47:0]      resp_hppa_o,
  output logic             resp_err_o,
  input  logic             inv_i
);
  att_state_e        state_q, state_d;
  logic [63:0]       araddr_q, araddr_d;
  logic [47:0]       hppa_q, hppa_d;
  logic              err_q, err_d;      // sticky AXI error across the burst
  logic              got_q, got_d;      // beat 0 already captured
  logic [AXI_DW-1:0] beat0_q, beat0_d;
  att_lkup_resppkt_t resp_q, resp_d;

  logic [63:0]       req_blk;
  logic              req_in_range;
  logic              hit;
  logic              beat_err;
  logic [AXI_DW-1:0] fetch_blk;
  logic [AXI_DW-1:0] ext_blk;
  logic [SLOT_W-1:0] ext_slot;
  AttEntry           ext_entry;

  assign req_blk      = att_blk_addr(ATT_BASE, lkup_req_i.hppa);
  assign req_in_range = {16'b0, lkup_req_i.hppa} < 64'(ENTRY_CNT);
  assign beat_err     = axi.rresp != AXI_RESP_OKAY;
  // On a single-beat burst beat 0 is still on the bus, not yet in beat0_q.
  assign fetch_blk    = got_q ? beat0_q : axi.rdata;
  assign ext_slot     = (state_q == ST_IDLE) ? lkup_req_i.hppa[SLOT_W-1:0]
                                             : hppa_q[SLOT_W-1:0];

`ifdef HAWK_ATT_LKUP_CACHE_EN
  logic              cvalid_q, cvalid_d;
  logic [63:0]       ctag_q, ctag_d;
  logic [AXI_DW-1:0] cdata_q, cdata_d;

  // inv_i takes effect in the same cycle, so it also blocks a hit.
  assign hit     = cvalid_q && !inv_i && (ctag_q == req_blk);
  assign ext_blk = (state_q == ST_IDLE) ? cdata_q : fetch_blk;

  always_comb begin
    cvalid_d = cvalid_q;
    ctag_d   = ctag_q;
    cdata_d  = cdata_q;
    if (state_q == ST_R && axi.rvalid && axi.rlast && !err_q && !beat_err) begin
      cvalid_d = 1'b1;
      ctag_d   = araddr_q;
      cdata_d  = fetch_blk;
    end
    if (inv_i) cvalid_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cvalid_q <= 1'b0;
      ctag_q   <= '0;
      cdata_q  <= '0;
    end else begin
      cvalid_q <= cvalid_d;
      ctag_q   <= ctag_d;
      cdata_q  <= cdata_d;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign hit        = 1'b0;
  assign ext_blk    = fetch_blk;
`endif

  hawk_att_blk_extract u_extract (
    .blk_i   (ext_blk),
    .slot_i  (ext_slot),
    .entry_o (ext_entry)
  );

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    hppa_d   = hppa_q;
    err_d    = err_q;
    got_d    = got_q;
    beat0_d  = beat0_q;
    resp_d   = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (lkup_req_i.lookup) begin
          hppa_d = lkup_req_i.hppa;
          err_d  = 1'b0;
          got_d  = 1'b0;
          if (!req_in_range) begin
            resp_d  = '{entry: '0, hppa: lkup_req_i.hppa, err: 1'b1, valid: 1'b1};
            state_d = ST_RESP;
          end else if (hit) begin
            resp_d  = '{entry: ext_entry, hppa: lkup_req_i.hppa, err: 1'b0, valid: 1'b1};
            state_d = ST_RESP;
          end else begin
            araddr_d = req_blk;
            state_d  = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (axi.arready) state_d = ST_R;
      end
      ST_R: begin
        if (axi.rvalid) begin
          if (!got_q) begin
            beat0_d = axi.rdata;
            got_d   = 1'b1;
          end
          if (beat_err) err_d = 1'b1;
          if (axi.rlast) begin
            resp_d  = '{entry: ext_entry, hppa: hppa_q, err: err_q | beat_err, valid: 1'b1};
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          resp_d.valid = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      hppa_q   <= '0;
      err_q    <= 1'b0;
      got_q    <= 1'b0;
      beat0_q  <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      hppa_q   <= hppa_d;
      err_q    <= err_d;
      got_q    <= got_d;
      beat0_q  <= beat0_d;
      resp_q   <= resp_d;
    end
  end

  assign lkup_ready_o = state_q == ST_IDLE;
  assign axi.arvalid  = state_q == ST_AR;
  assign axi.rready   = state_q == ST_R;
  assign axi.araddr   = araddr_q;
  assign resp_valid_o = resp_q.valid;
  assign resp_entry_o = resp_q.entry;
  assign resp_hppa_o  = resp_q.hppa;
  assign resp_err_o   = resp_q.err;
endmodule

// File: tb/tb_hawk_att_lkup.sv
module tb_hawk_att_lkup;
  import hawk_att_lkup_pkg::*;

  localparam logic [63:0] BASE = 64'hFFF6100000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  att_lkup_reqpkt_t lkup_req;
  logic             lkup_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [63:0]      resp_entry;
  logic [47:0]      resp_hppa;
  logic             resp_err;
  logic             inv;

  hawk_att_lkup_if axi_if ();

  hawk_att_lkup dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .lkup_req_i   (lkup_req),
    .lkup_ready_o (lkup_ready),
    .axi          (axi_if),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_entry_o (resp_entry),
    .resp_hppa_o  (resp_hppa),
    .resp_err_o   (resp_err),
    .inv_i        (inv)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference ATT image; the AXI slave serves blocks laid out by address.
  logic [63:0] mem [16];

  // Model of the expected outcome of the lookup in flight.
  bit          active = 0;
  bit          exp_ar = 0;
  bit          exp_chk_entry = 0;
  logic [63:0] exp_addr = '0;
  logic [63:0] exp_entry = '0;
  logic [47:0] exp_hppa = '0;
  logic        exp_err = 1'b0;
  bit          m_cvalid = 0;
  logic [44:0] m_cblk = '0;

  // AXI slave configuration and observations
  int          cfg_nb = 1, cfg_ardly = 0, cfg_errb = -1;
  bit          stray = 0;
  int          rlast_edge = 0;
  logic [63:0] last_araddr = '0;

  initial begin
    logic [63:0]  a, off;
    logic [511:0] blk;
    int           idx;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rlast   = 1'b0;
    axi_if.rresp   = 2'b00;
    axi_if.rdata   = '0;
    forever begin
      @(negedge clk);
      if (!rst && axi_if.arvalid) begin
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
        axi_if.rresp  = 2'b00;
        repeat (cfg_ardly) @(negedge clk);
        a = axi_if.araddr;
        last_araddr = a;
        axi_if.arready = 1'b1;
        @(negedge clk);
        axi_if.arready = 1'b0;
        off = a - BASE;
        idx = int'(off[63:6]);
        for (int k = 0; k < 8; k++)
          blk[k*64 +: 64] = (off < 64'd128 && idx*8 + k < 16) ? mem[idx*8 + k] : {$urandom, $urandom};
        for (int b = 0; b < cfg_nb; b++) begin
          if (rst) break;
          if ($urandom_range(0, 2) == 0) begin
            axi_if.rvalid = 1'b0;
            @(negedge clk);
            if (rst) break;
          end
          axi_if.rvalid = 1'b1;
          axi_if.rdata  = (b == 0) ? blk : {16{$urandom}};
          axi_if.rresp  = (b == cfg_errb) ? 2'b10 : 2'b00;
          axi_if.rlast  = (b == cfg_nb - 1);
          if (b == cfg_nb - 1) rlast_edge = cyc + 1;
          @(negedge clk);
        end
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
        axi_if.rresp  = 2'b00;
      end else begin
        // Beats outside a burst must be ignored by the DUT.
        axi_if.rvalid = stray;
        axi_if.rlast  = stray;
        axi_if.rresp  = stray ? 2'b10 : 2'b00;
        axi_if.rdata  = {16{$urandom}};
      end
    end
  end

  // Compare process: checks DUT outputs against the model every cycle.
  int ar_total = 0;
  int ar_rise_cyc = -1;
  logic ar_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_exclusive", lkup_ready && (axi_if.arvalid || axi_if.rready || resp_valid), 0);
      if (axi_if.arvalid) begin
        if (!ar_prev) ar_rise_cyc <= cyc;
        ar_total <= ar_total + 1;
        chk("ar_expected", exp_ar && active, 1);
        chk("araddr", axi_if.araddr, exp_addr);
      end
      if (resp_valid) begin
        chk("resp_while_active", active, 1);
        chk("resp_hppa", resp_hppa, exp_hppa);
        chk("resp_err", resp_err, exp_err);
        if (exp_chk_entry) chk("resp_entry", resp_entry, exp_entry);
      end
    end
    ar_prev <= axi_if.arvalid;
  end

  logic [63:0] last_entry;
  logic        last_err;

  task automatic run_lookup(input logic [47:0] h, input int nb, input int ardly,
                            input int errb, input int respdly);
    int t, ar0, acc_edge, resp_cyc;
    bit oor;
    oor = (h >= 48'd16);
`ifdef HAWK_ATT_LKUP_CACHE_EN
    exp_ar = !oor && !(m_cvalid && m_cblk == h[47:3]);
`else
    exp_ar = !oor;
`endif
    exp_hppa      = h;
    exp_err       = oor || (exp_ar && errb >= 0 && errb < nb);
    exp_entry     = oor ? 64'd0 : mem[h[3:0]];
    exp_chk_entry = !(exp_err && !oor);
    exp_addr      = BASE + ((64'(h) * 64'd8) & ~64'h3F);
    cfg_nb = nb; cfg_ardly = ardly; cfg_errb = errb;
    ar0 = ar_total;
    active = 1;
    t = 0;
    while (!lkup_ready && t < 50) begin @(negedge clk); t++; end
    chk("ready_timeout", lkup_ready, 1);
    lkup_req.hppa   = h;
    lkup_req.lookup = 1'b1;
    acc_edge = cyc + 1;
    @(posedge clk);
    #1 lkup_req.lookup = 1'b0;
    @(negedge clk);
    t = 0;
    while (!resp_valid && t < 100) begin @(negedge clk); t++; end
    chk("resp_timeout", resp_valid, 1);
    resp_cyc   = cyc;
    last_entry = resp_entry;
    last_err   = resp_err;
    if (exp_ar) begin
      chk("ar_rise_latency", ar_rise_cyc, acc_edge);
      chk("ar_cycles", ar_total - ar0, ardly + 1);
      chk("resp_after_rlast", resp_cyc, rlast_edge);
    end else begin
      chk("no_ar", ar_total - ar0, 0);
      chk("resp_latency_noar", resp_cyc, acc_edge);
    end
    stray = (respdly > 0);
    repeat (respdly) @(negedge clk);
    stray = 0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("resp_dropped", resp_valid, 0);
    if (exp_ar && !exp_err) begin
      m_cvalid = 1;
      m_cblk   = h[47:3];
    end
    active = 0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_lkup_ready"}, lkup_ready, 1);
    chk({tag, "_arvalid"}, axi_if.arvalid, 0);
    chk({tag, "_rready"}, axi_if.rready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_araddr"}, axi_if.araddr, 0);
    chk({tag, "_entry"}, resp_entry, 0);
    chk({tag, "_hppa"}, resp_hppa, 0);
    chk({tag, "_err"}, resp_err, 0);
  endtask

  task automatic pulse_inv();
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    m_cvalid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, snap;
    lkup_req   = '0;
    resp_ready = 1'b0;
    inv        = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // hppa=5, single beat, immediate arready
    mem[5] = 64'h0100000000012346;
    run_lookup(48'd5, 1, 0, -1, 0);
    chk("t1_araddr", last_araddr, 64'hFFF6100000);
    chk("t1_sts", last_entry[1:0], 2'b10);
    chk("t1_zpd", last_entry[63:56], 8'h01);
    chk("t1_err", last_err, 0);

    // hppa=9, arready held off 3 cycles
    mem[9] = 64'hDEADBEEF00000909;
    run_lookup(48'd9, 1, 3, -1, 0);
    chk("t2_araddr", last_araddr, 64'hFFF6100040);
    chk("t2_entry", last_entry, 64'hDEADBEEF00000909);

    // out of range
    run_lookup(48'd16, 1, 0, -1, 0);
    chk("t3_err", last_err, 1);
    chk("t3_entry", last_entry, 0);

    // two-beat burst, SLVERR on beat 2
    run_lookup(48'd3, 2, 0, 1, 0);
    chk("t4_err", last_err, 1);

    // consumer stalls 5 cycles with stray beats on R
    run_lookup(48'd12, 3, 1, -1, 5);

    // repeated block: cache hit only with the cache option
    pulse_inv();
    run_lookup(48'd1, 1, 0, -1, 0);
    snap = ar_total;
    run_lookup(48'd6, 1, 0, -1, 0);
`ifdef HAWK_ATT_LKUP_CACHE_EN
    chk("cache_hit_noar", ar_total - snap, 0);
`else
    chk("nocache_ar", ar_total - snap, 1);
`endif
    pulse_inv();
    snap = ar_total;
    run_lookup(48'd6, 1, 0, -1, 0);
    chk("after_inv_ar", ar_total - snap, 1);

    // randomized lookups
    for (int i = 0; i < 40; i++) begin
      logic [47:0] h;
      int nb, ardly, errb, rdly, j;
      if ($urandom_range(0, 5) == 0) begin
        j = $urandom_range(0, 15);
        mem[j] = {$urandom, $urandom};
        pulse_inv();
      end
      h     = ($urandom_range(0, 5) == 0) ? ({$urandom, 16'h0} | 48'h10) : 48'($urandom_range(0, 15));
      nb    = $urandom_range(1, 4);
      ardly = $urandom_range(0, 3);
      errb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
      rdly  = $urandom_range(0, 3);
      run_lookup(h, nb, ardly, errb, rdly);
    end

    // reset asserted while in R
    pulse_inv();
    exp_ar = 1; exp_hppa = 48'd2; exp_addr = BASE; exp_err = 0;
    exp_entry = mem[2]; exp_chk_entry = 1;
    cfg_nb = 4; cfg_ardly = 0; cfg_errb = -1;
    active = 1;
    lkup_req.hppa   = 48'd2;
    lkup_req.lookup = 1'b1;
    @(posedge clk);
    #1 lkup_req.lookup = 1'b0;
    t = 0;
    while (!axi_if.rready && t < 50) begin @(negedge clk); t++; end
    chk("mid_rready_seen", axi_if.rready, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    active = 0;
    m_cvalid = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_midreset");
    run_lookup(48'd7, 2, 1, -1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
